// File: rtl/sdram_fill_resp.sv
// rtl/sdram_fill_resp.sv - burst fill responder: pipelined SDRAM reads streamed into data memory
// Optional length clamp to the data-memory size: define SDRAM_FILL_CLAMP_EN.
module sdram_fill_resp #(
    parameter int ADDR_W  = 25,
    parameter int LEN_W   = 25,
    parameter int DM_AW   = 16,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic              ref_clk,
    input  logic              rst_n,
    input  logic              request,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              granted,
    output logic              busy,
    output logic              done,
`ifdef SDRAM_FILL_CLAMP_EN
    output logic              len_err,
`endif
    output logic              sd_rd_req,
    output logic [ADDR_W-1:0] sd_rd_addr,
    input  logic              sd_rd_ack,
    input  logic              sd_rd_valid,
    input  logic [DATA_W-1:0] sd_rd_data,
    output logic              dm_wr_en,
    output logic [DM_AW-1:0]  dm_wr_addr,
    output logic [DATA_W-1:0] dm_wr_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_OUT_L = LEN_W'(MAX_OUT);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    iss_q, iss_d;
    logic [LEN_W-1:0]    rcv_q, rcv_d;
    logic                wr_en_q, wr_en_d;
    logic [DM_AW-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic                accept;
    logic [LEN_W-1:0]    outstanding;
    logic                issue_ok;
    logic                rcv_ok;
    logic [LEN_W-1:0]    len_eff;

    assign accept      = (state_q == S_IDLE) && request;
    assign outstanding = iss_q - rcv_q;
    // Request depends only on registered counters, so it cannot drop before the ack.
    assign issue_ok    = (state_q == S_XFER) && (iss_q < len_q) && (outstanding < MAX_OUT_L);
    // Returns with nothing outstanding (stale or stray) never reach data memory.
    assign rcv_ok      = (state_q == S_XFER) && sd_rd_valid && (outstanding != '0);

`ifdef SDRAM_FILL_CLAMP_EN
    localparam logic [LEN_W:0] DM_WORDS = (LEN_W+1)'(1) << DM_AW;

    logic len_err_q, len_err_d;
    logic too_long;

    assign too_long  = {1'b0, length} > DM_WORDS;
    assign len_eff   = too_long ? DM_WORDS[LEN_W-1:0] : length;
    assign len_err_d = len_err_q | (accept && too_long);
    assign len_err   = len_err_q;

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= len_err_d;
        end
    end
`else
    assign len_eff = length;
`endif

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving XFER waits for the cycle in which the final write is visible,
    // so busy still covers that write and DONE never carries one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (request) state_d = S_XFER;
            S_XFER:  if (rcv_q == len_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        granted   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        sd_rd_req = 1'b0;
        case (state_q)
            S_XFER: begin
                granted   = 1'b1;
                busy      = 1'b1;
                sd_rd_req = issue_ok;
            end
            S_DONE: begin
                granted = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        start_d   = start_q;
        len_d     = len_q;
        iss_d     = iss_q;
        rcv_d     = rcv_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (accept) begin
            start_d = start_addr;
            len_d   = len_eff;
            iss_d   = '0;
            rcv_d   = '0;
        end
        if (issue_ok && sd_rd_ack) begin
            iss_d = iss_q + ONE_L;
        end
        if (rcv_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = rcv_q[DM_AW-1:0];
            wr_data_d = sd_rd_data;
            rcv_d     = rcv_q + ONE_L;
        end
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= '0;
            len_q     <= '0;
            iss_q     <= '0;
            rcv_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            start_q   <= start_d;
            len_q     <= len_d;
            iss_q     <= iss_d;
            rcv_q     <= rcv_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign sd_rd_addr = start_q + ADDR_W'(iss_q);
    assign dm_wr_en   = wr_en_q;
    assign dm_wr_addr = wr_addr_q;
    assign dm_wr_data = wr_data_q;

endmodule

// File: tb/tb_sdram_fill_resp.sv
// tb/tb_sdram_fill_resp.sv - randomized bench for sdram_fill_resp against a transfer-level model
module tb_sdram_fill_resp;

    localparam int ADDR_W  = 25;
    localparam int LEN_W   = 25;
    localparam int DM_AW   = 16;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 4;

    logic              ref_clk = 1'b0;
    logic              rst_n;
    logic              request;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  length;
    logic              granted, busy, done;
    logic              sd_rd_req;
    logic [ADDR_W-1:0] sd_rd_addr;
    logic              sd_rd_ack;
    logic              sd_rd_valid;
    logic [DATA_W-1:0] sd_rd_data;
    logic              dm_wr_en;
    logic [DM_AW-1:0]  dm_wr_addr;
    logic [DATA_W-1:0] dm_wr_data;
`ifdef SDRAM_FILL_CLAMP_EN
    logic              len_err;
`endif

    sdram_fill_resp #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DM_AW(DM_AW), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .ref_clk(ref_clk), .rst_n(rst_n), .request(request),
        .start_addr(start_addr), .length(length),
        .granted(granted), .busy(busy), .done(done),
`ifdef SDRAM_FILL_CLAMP_EN
        .len_err(len_err),
`endif
        .sd_rd_req(sd_rd_req), .sd_rd_addr(sd_rd_addr), .sd_rd_ack(sd_rd_ack),
        .sd_rd_valid(sd_rd_valid), .sd_rd_data(sd_rd_data),
        .dm_wr_en(dm_wr_en), .dm_wr_addr(dm_wr_addr), .dm_wr_data(dm_wr_data)
    );

    always #5 ref_clk = ~ref_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // SDRAM read port model: in-order returns, each no earlier than issue + lat
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } rd_t;
    rd_t mem_q[$];
    int  lat      = 1;
    int  ack_mode = 0;
    bit  stray_req = 1'b0;
    int  cyc = 0;

    // Transfer-level reference: phase 0 idle, 1 transferring, 2 done
    int                m_st = 0;
    logic [ADDR_W-1:0] m_start;
    int                m_len, m_iss, m_rcv;
    bit                m_wp;
    int                m_wa;
    logic [DATA_W-1:0] m_wd;

    int n_gr, n_busy, n_done, n_reqc, n_wr, n_stray, hs_cnt, max_out;
    bit addr_moved, stalled_prev;
    logic [ADDR_W-1:0] prev_addr;
    logic [ADDR_W-1:0] iss_log[$];

    task automatic clear_stats();
        n_gr = 0; n_busy = 0; n_done = 0; n_reqc = 0; n_wr = 0; n_stray = 0;
        hs_cnt = 0; max_out = 0; addr_moved = 1'b0;
        iss_log.delete();
    endtask

    initial begin : responder
        bit                exp_req, ack, ret_ok, done_now;
        int                outst;
        logic [ADDR_W-1:0] e_addr;
        rd_t               r;
        forever begin
            @(negedge ref_clk);
            cyc++;
            exp_req = 1'b0;
            if (!rst_n) begin
                chk("rst_ctrl_outputs", {granted, busy, done, sd_rd_req, dm_wr_en}, 0);
                chk("rst_data_outputs", longint'(sd_rd_addr) | longint'(dm_wr_addr) | longint'(dm_wr_data), 0);
                m_st = 0;
                m_wp = 1'b0;
            end else begin
                exp_req = (m_st == 1) && (m_iss < m_len) && (m_iss - m_rcv < MAX_OUT);
                chk("granted", granted, m_st != 0);
                chk("busy", busy, m_st == 1);
                chk("done", done, m_st == 2);
                chk("sd_rd_req", sd_rd_req, exp_req);
                if (exp_req) begin
                    e_addr = m_start + ADDR_W'(m_iss);
                    chk("sd_rd_addr", sd_rd_addr, e_addr);
                end
                chk("dm_wr_en", dm_wr_en, m_wp);
                if (m_wp) begin
                    chk("dm_wr_addr", dm_wr_addr, m_wa % (2 ** DM_AW));
                    chk("dm_wr_data", dm_wr_data, m_wd);
                end
                n_gr   += int'(granted);
                n_busy += int'(busy);
                n_done += int'(done);
                n_reqc += int'(sd_rd_req);
                n_wr   += int'(dm_wr_en);
                if (stalled_prev && sd_rd_req && sd_rd_addr != prev_addr) addr_moved = 1'b1;
                if (hs_cnt - n_wr > max_out) max_out = hs_cnt - n_wr;
            end

            case (ack_mode)
                0:       ack = 1'b1;
                1:       ack = (cyc % 3 == 0);
                default: ack = ($urandom_range(0, 1) == 1);
            endcase
            sd_rd_ack    = ack;
            stalled_prev = sd_rd_req && !ack;
            prev_addr    = sd_rd_addr;
            if (rst_n && sd_rd_req && ack) begin
                r.due  = cyc + lat;
                r.data = $urandom;
                mem_q.push_back(r);
                hs_cnt++;
                iss_log.push_back(sd_rd_addr);
            end
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                r = mem_q.pop_front();
                sd_rd_valid = 1'b1;
                sd_rd_data  = r.data;
            end else if (stray_req) begin
                stray_req   = 1'b0;
                sd_rd_valid = 1'b1;
                sd_rd_data  = $urandom;
            end else begin
                sd_rd_valid = 1'b0;
                sd_rd_data  = $urandom;
            end
            if (sd_rd_valid && (m_st == 0 || !rst_n)) n_stray++;

            if (rst_n) begin
                m_wp = 1'b0;
                case (m_st)
                    0: if (request) begin
                        m_start = start_addr;
                        m_len   = int'(length);
                        m_iss   = 0;
                        m_rcv   = 0;
                        m_st    = 1;
                    end
                    1: begin
                        outst    = m_iss - m_rcv;
                        done_now = (m_rcv == m_len);
                        if (exp_req && ack) m_iss++;
                        ret_ok = sd_rd_valid && (outst > 0);
                        if (ret_ok) begin
                            m_wp = 1'b1;
                            m_wa = m_rcv;
                            m_wd = sd_rd_data;
                            m_rcv++;
                        end
                        if (done_now) m_st = 2;
                    end
                    default: m_st = 0;
                endcase
            end
        end
    end

    task automatic run_xfer(input logic [ADDR_W-1:0] s, input int l, input bit hold, input bit scramble);
        int t;
        clear_stats();
        start_addr = s;
        length     = LEN_W'(l);
        request    = 1'b1;
        t = 0;
        do begin
            @(posedge ref_clk); #1; t++;
        end while (!granted && t < 50);
        chk("accept_timeout", granted, 1);
        if (!hold) request = 1'b0;
        t = 0;
        while (n_done < 1 && t < 3000) begin
            @(posedge ref_clk); #1; t++;
            if (scramble) begin
                start_addr = ADDR_W'($urandom);
                length     = LEN_W'($urandom_range(0, 12));
            end
        end
        chk("done_timeout", n_done >= 1, 1);
        if (hold) begin
            @(posedge ref_clk); #1;
            request = 1'b0;
            t = 0;
            while (n_done < 2 && t < 3000) begin
                @(posedge ref_clk); #1; t++;
            end
            chk("b2b_done_count", n_done, 2);
        end
        repeat (2) @(posedge ref_clk);
        #1;
    endtask

    logic [ADDR_W-1:0] exp_basic[4];
    logic [ADDR_W-1:0] exp_wrap[4];

    initial begin : main
        int t;
        bit hold;
        rst_n = 1'b0; request = 1'b0; start_addr = '0; length = '0;
        sd_rd_ack = 1'b0; sd_rd_valid = 1'b0; sd_rd_data = '0;
        exp_basic = '{25'h400, 25'h401, 25'h402, 25'h403};
        exp_wrap  = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h0, 25'h1};
        clear_stats();
        repeat (3) @(posedge ref_clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge ref_clk);
        #1;
        chk("idle_granted", granted, 0);
        chk("idle_req", sd_rd_req, 0);
        chk("idle_wr_en", dm_wr_en, 0);

        ack_mode = 0; lat = 1;
        run_xfer(25'h400, 4, 1'b0, 1'b0);
        chk("basic_issue_count", iss_log.size(), 4);
        for (int i = 0; i < 4 && i < iss_log.size(); i++) chk("basic_addr", iss_log[i], exp_basic[i]);
        chk("basic_writes", n_wr, 4);
        chk("basic_done", n_done, 1);

        ack_mode = 1; lat = 8;
        run_xfer(25'h2000, 16, 1'b0, 1'b0);
        chk("bp_max_outstanding_le4", max_out <= MAX_OUT, 1);
        chk("bp_addr_stable", addr_moved, 0);
        chk("bp_writes", n_wr, 16);

        ack_mode = 0; lat = 1;
        run_xfer(25'h123, 0, 1'b0, 1'b0);
        chk("len0_granted_cycles", n_gr, 2);
        chk("len0_busy_cycles", n_busy, 1);
        chk("len0_done", n_done, 1);
        chk("len0_req_cycles", n_reqc, 0);
        chk("len0_writes", n_wr, 0);

        run_xfer(25'h1FFFFFE, 4, 1'b0, 1'b0);
        chk("wrap_issue_count", iss_log.size(), 4);
        for (int i = 0; i < 4 && i < iss_log.size(); i++) chk("wrap_addr", iss_log[i], exp_wrap[i]);

        lat = 5;
        clear_stats();
        start_addr = 25'h800; length = 25'd8; request = 1'b1;
        @(posedge ref_clk); #1;
        request = 1'b0;
        t = 0;
        while (n_wr < 2 && t < 200) begin
            @(posedge ref_clk); #1; t++;
        end
        chk("abort_progress", n_wr >= 2, 1);
        rst_n = 1'b0;
        repeat (2) @(posedge ref_clk);
        #1 rst_n = 1'b1;
        clear_stats();
        stray_req = 1'b1;
        repeat (12) @(posedge ref_clk);
        #1;
        chk("abort_no_writes", n_wr, 0);
        chk("abort_no_done", n_done, 0);
        chk("abort_not_granted", n_gr, 0);
        chk("abort_stray_seen", n_stray >= 1, 1);
        run_xfer(25'h800, 8, 1'b0, 1'b0);
        chk("post_abort_writes", n_wr, 8);
        chk("post_abort_done", n_done, 1);

        for (int it = 0; it < 40; it++) begin
            lat      = $urandom_range(1, 6);
            ack_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
            hold     = ($urandom_range(0, 3) == 0);
            run_xfer(ADDR_W'($urandom), $urandom_range(0, 12), hold, 1'b1);
            chk("rand_outstanding_le4", max_out <= MAX_OUT, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checks);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
